axi_mem_responder: RTL and testbench
====================================

# axi_mem_responder

AXI4 memory responder: the slave end of the read and write channels driven by the data cache and instruction cache. It holds a word-addressed 64-bit backing store and services one burst at a time, either read or write. It returns read data with a configurable latency and applies byte strobes on writes. It sits behind the AXI arbiter in place of external DRAM for simulation and bring-up.

## Interface
- ADDR_WIDTH, 64: width of the araddr and awaddr buses.
- MEM_WORDS, 1024: number of 64-bit words in the store; must be a power of two.
- READ_LATENCY, 2: idle cycles between the AR handshake and the first rvalid; valid range is 0..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address accepted.
- s_axi_araddr  in  ADDR_WIDTH  byte address of the first beat.
- s_axi_arlen  in  8  beats minus one.
- s_axi_arsize  in  3  must be 3 (8 bytes).
- s_axi_arburst  in  2  ignored; always treated as INCR.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  master accepts read data.
- s_axi_rdata  out  64  read beat.
- s_axi_rlast  out  1  final read beat.
- s_axi_awvalid / s_axi_awready / s_axi_awaddr / s_axi_awlen / s_axi_awsize / s_axi_awburst: write address channel, same widths and rules as the AR channel.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data accepted.
- s_axi_wdata  in  64  write beat.
- s_axi_wstrb  in  8  byte enables.
- s_axi_wlast  in  1  final write beat.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  master accepts the response.
- s_axi_bresp  out  2  response code: 2'b00 OKAY, 2'b10 SLVERR.

## Operation
- States: IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP.
- Word index is addr[3 +: log2(MEM_WORDS)]; upper address bits are ignored. The index increments by 1 per beat and wraps modulo MEM_WORDS.
- IDLE:
  - arready is asserted when arvalid is high and the read is granted; awready follows the same rule for writes.
  - If only one channel is valid, that channel is granted.
  - If both are valid in the same cycle, grant alternates. The channel not serviced last wins; after reset, write wins.
  - Address, len, and index are latched on the handshake.
- Read path:
  - After the AR handshake, the block goes to RD_WAIT for READ_LATENCY cycles. With READ_LATENCY=0 it goes straight to RD_DATA.
  - RD_DATA: rvalid=1 and rdata=mem[index].
  - On rvalid&rready the beat count increments. rlast=1 when count==len.
  - After the rlast handshake the block returns to IDLE.
- Write path:
  - After the AW handshake the block goes to WR_DATA, where wready=1.
  - Each wvalid&wready beat writes the byte lanes of mem[index] that have wstrb set.
  - Normal end: wlast arrives on beat number len. The block goes to WR_RESP with bresp=OKAY.
  - Early wlast: that beat is written, the burst ends, and bresp=SLVERR.
  - Overrun: beats after number len are accepted but not written. The block stays in WR_DATA until wlast, then responds SLVERR.
  - awsize≠3 gives SLVERR; strobes are still applied.
  - WR_RESP: bvalid=1 and is held until bready; the block then returns to IDLE.
- arsize≠3 on a read: the burst is still served normally.

## Timing
- Reset values: arready, awready, rvalid, rlast, wready, bvalid = 0; rdata = 0; bresp = 0; state IDLE; arbitration pointer favours write. Memory contents are not reset.
- Reset asserted mid-burst aborts the burst immediately. All outputs take their reset values and no further memory writes occur.
- Ready signals are combinational from state and the valid inputs in IDLE. All other outputs are registered.
- Read timing, with the AR handshake at cycle T:
  - The first rvalid is at T+1+READ_LATENCY.
  - With rready held high, beat k is at T+1+READ_LATENCY+k.
  - rdata, rlast, and rvalid hold stable while rready=0.
- Write timing, with the AW handshake at T:
  - wready is high from T+1.
  - The wlast beat is at W; bvalid rises at W+1.
  - bvalid&bready at cycle B; the next AR/AW handshake is possible at B+1.
- A write beat and a later read of the same word: the read returns the post-strobe value.
- Throughput is one beat per cycle in both directions. There is at most one outstanding transaction.

## Test plan
- Single read: preload mem[4]=64'hDEAD_BEEF_0123_4567; araddr=0x20, arlen=0 -> rvalid at T+3 with that data, rlast=1.
- Read burst with backpressure: araddr=0, arlen=7, rready toggling 1,0 -> 8 beats mem[0..7] in order; rlast only on the 8th beat; rdata stable during stalls.
- Strobed write then readback: write 64'hFFFF_FFFF_FFFF_FFFF with wstrb=8'h0F to a word holding 0 -> bresp=00; read gives 64'h0000_0000_FFFF_FFFF.
- Simultaneous AR and AW out of reset: write granted first; the next simultaneous pair grants read.
- Mismatched bursts: awlen=3 with wlast on beat 1 -> SLVERR and only 2 words written; awlen=1 with wlast on beat 3 -> SLVERR and only 2 words written.
- Wrap and reset: araddr=(MEM_WORDS-1)*8, arlen=1 -> returns mem[MEM_WORDS-1] then mem[0]. Reset asserted on the second beat -> rvalid drops in the same cycle and the next read is served normally.

Source files
------------

// File: rtl/axi_mem_responder.sv
// AXI4 slave memory: 64-bit word store serving one read or write burst at a time.
// Latency: first read beat READ_LATENCY+1 cycles after AR; write response one cycle after wlast.
// Backpressure: rvalid/rdata/rlast hold while rready=0; bvalid holds until bready; one beat per cycle.
module axi_mem_responder #(
    parameter int ADDR_WIDTH   = 64,
    parameter int MEM_WORDS    = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [63:0]           s_axi_rdata,
    output logic                  s_axi_rlast,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    input  logic [63:0]           s_axi_wdata,
    input  logic [7:0]            s_axi_wstrb,
    input  logic                  s_axi_wlast,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic [1:0]            s_axi_bresp
);
    localparam int         IW          = $clog2(MEM_WORDS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    // RD_WAIT lasts READ_LATENCY cycles: the counter runs from latency-1 down to 0
    localparam logic [3:0] WAIT_INIT   = (READ_LATENCY == 0) ? 4'd0 : 4'(READ_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP} state_t;

    state_t        state;
    logic [63:0]   mem [MEM_WORDS];
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_next;
    logic [IW-1:0] ar_idx;
    logic [IW-1:0] aw_idx;
    logic [7:0]    len;
    logic [7:0]    beat_cnt;
    logic [3:0]    wait_cnt;
    logic          prefer_wr;
    logic          wr_err;
    logic          wr_over;
    logic          grant_rd;
    logic          grant_wr;
    logic          ar_hs;
    logic          aw_hs;
    logic          r_hs;
    logic          w_hs;
    logic          mem_we;

    // Address bits outside the word index and the burst/read-size fields do not affect behaviour
    logic unused_bits;
    assign unused_bits = ^{s_axi_araddr[ADDR_WIDTH-1:3+IW], s_axi_araddr[2:0],
                           s_axi_awaddr[ADDR_WIDTH-1:3+IW], s_axi_awaddr[2:0],
                           s_axi_arsize, s_axi_arburst, s_axi_awburst};

    assign ar_idx   = s_axi_araddr[3 +: IW];
    assign aw_idx   = s_axi_awaddr[3 +: IW];
    assign idx_next = idx + 1'b1;

    // Arbitration: a lone request wins; on a tie the channel not serviced last wins
    always_comb begin
        grant_wr = s_axi_awvalid && (!s_axi_arvalid || prefer_wr);
        grant_rd = s_axi_arvalid && (!s_axi_awvalid || !prefer_wr);
    end

    assign s_axi_arready = !reset && (state == IDLE) && grant_rd;
    assign s_axi_awready = !reset && (state == IDLE) && grant_wr;
    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign r_hs   = s_axi_rvalid && s_axi_rready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;
    // Beats past the declared length are accepted but discarded
    assign mem_we = w_hs && !wr_over;

    // Backing store write with per-byte strobes; wready is cleared by reset so nothing lands then
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (s_axi_wstrb[b]) mem[idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    // Burst sequencer with registered channel outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            s_axi_rvalid <= 1'b0;
            s_axi_rlast  <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_wready <= 1'b0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
            prefer_wr    <= 1'b1;
            idx          <= '0;
            len          <= '0;
            beat_cnt     <= '0;
            wait_cnt     <= '0;
            wr_err       <= 1'b0;
            wr_over      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        prefer_wr <= 1'b1;
                        idx       <= ar_idx;
                        len       <= s_axi_arlen;
                        beat_cnt  <= '0;
                        if (READ_LATENCY == 0) begin
                            state        <= RD_DATA;
                            s_axi_rvalid <= 1'b1;
                            s_axi_rdata  <= mem[ar_idx];
                            s_axi_rlast  <= (s_axi_arlen == 8'd0);
                        end else begin
                            state    <= RD_WAIT;
                            wait_cnt <= WAIT_INIT;
                        end
                    end else if (aw_hs) begin
                        prefer_wr    <= 1'b0;
                        idx          <= aw_idx;
                        len          <= s_axi_awlen;
                        beat_cnt     <= '0;
                        wr_err       <= (s_axi_awsize != 3'd3);
                        wr_over      <= 1'b0;
                        s_axi_wready <= 1'b1;
                        state        <= WR_DATA;
                    end
                end
                RD_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state        <= RD_DATA;
                        s_axi_rvalid <= 1'b1;
                        s_axi_rdata  <= mem[idx];
                        s_axi_rlast  <= (len == 8'd0);
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RD_DATA: begin
                    if (r_hs) begin
                        if (s_axi_rlast) begin
                            state        <= IDLE;
                            s_axi_rvalid <= 1'b0;
                            s_axi_rlast  <= 1'b0;
                        end else begin
                            beat_cnt    <= beat_cnt + 8'd1;
                            idx         <= idx_next;
                            s_axi_rdata <= mem[idx_next];
                            s_axi_rlast <= (beat_cnt + 8'd1 == len);
                        end
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        if (s_axi_wlast) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bresp  <= (wr_err || wr_over || beat_cnt != len) ? RESP_SLVERR : RESP_OKAY;
                            state        <= WR_RESP;
                        end else if (beat_cnt == len) begin
                            wr_over <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                            idx      <= idx_next;
                        end
                    end
                end
                WR_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid <= 1'b0;
                        s_axi_bresp  <= RESP_OKAY;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomized bench for axi_mem_responder against a word-array reference model.
// Latency: checks first rvalid at handshake+1+READ_LATENCY and bvalid one cycle after wlast.
// Backpressure: drives toggling/random rready and delayed bready.
module tb_axi_mem_responder;
    localparam int MW = 1024;
    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_axi_arvalid = 0, s_axi_arready;
    logic [63:0] s_axi_araddr = '0;
    logic [7:0]  s_axi_arlen = '0;
    logic [2:0]  s_axi_arsize = 3'd3;
    logic [1:0]  s_axi_arburst = 2'd1;
    logic        s_axi_rvalid, s_axi_rready = 0, s_axi_rlast;
    logic [63:0] s_axi_rdata;
    logic        s_axi_awvalid = 0, s_axi_awready;
    logic [63:0] s_axi_awaddr = '0;
    logic [7:0]  s_axi_awlen = '0;
    logic [2:0]  s_axi_awsize = 3'd3;
    logic [1:0]  s_axi_awburst = 2'd1;
    logic        s_axi_wvalid = 0, s_axi_wready, s_axi_wlast = 0;
    logic [63:0] s_axi_wdata = '0;
    logic [7:0]  s_axi_wstrb = '0;
    logic        s_axi_bvalid, s_axi_bready = 0;
    logic [1:0]  s_axi_bresp;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] mdl [MW];

    always #5 clk = ~clk;

    axi_mem_responder #(.ADDR_WIDTH(64), .MEM_WORDS(MW), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset(reset),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
        .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
        .s_axi_rlast(s_axi_rlast),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
        .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
        .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp)
    );

    // Byte address for word idx with random ignored upper bits
    function automatic logic [63:0] mk_addr(input int idx);
        logic [63:0] a;
        a = {$urandom, $urandom};
        a[3 +: 10] = idx[9:0];
        a[2:0] = 3'd0;
        return a;
    endfunction

    // All drive tasks start at a falling edge and return at a falling edge
    task automatic drive_ar(input int idx, input int len, input logic [2:0] size, output int waits);
        s_axi_arvalid = 1; s_axi_araddr = mk_addr(idx); s_axi_arlen = len[7:0];
        s_axi_arsize = size; s_axi_arburst = 2'($urandom);
        waits = 0; #1;
        while (s_axi_arready !== 1'b1 && waits < 50) begin @(negedge clk); #1; waits++; end
        n_vec++;
        if (s_axi_arready !== 1'b1) begin n_err++; $display("FAIL ar_handshake: arready=%b required 1", s_axi_arready); end
        @(posedge clk);
    endtask

    task automatic drive_aw(input int idx, input int len, input logic [2:0] size, output int waits);
        s_axi_awvalid = 1; s_axi_awaddr = mk_addr(idx); s_axi_awlen = len[7:0];
        s_axi_awsize = size; s_axi_awburst = 2'($urandom);
        waits = 0; #1;
        while (s_axi_awready !== 1'b1 && waits < 50) begin @(negedge clk); #1; waits++; end
        n_vec++;
        if (s_axi_awready !== 1'b1) begin n_err++; $display("FAIL aw_handshake: awready=%b required 1", s_axi_awready); end
        @(posedge clk);
    endtask

    // mode 0: rready high, 1: rready 1,0,1,0..., 2: random rready
    task automatic read_beats(input int idx, input int len, input int mode);
        int k = 0;
        int cyc = 0;
        bit seen = 0;
        bit tog = 1;
        while (k <= len && cyc < 300) begin
            @(negedge clk); cyc++;
            s_axi_arvalid = 0; s_axi_awvalid = 0;
            if (s_axi_rvalid === 1'b1) begin
                if (!seen) begin
                    n_vec++;
                    if (cyc != 1 + RL) begin n_err++; $display("FAIL read_latency: first rvalid at cycle %0d required %0d", cyc, 1 + RL); end
                end
                seen = 1;
                n_vec++;
                if (s_axi_rdata !== mdl[(idx + k) % MW] || s_axi_rlast !== (k == len)) begin
                    n_err++;
                    $display("FAIL read_beat %0d word %0d: rdata=%h rlast=%b required %h %b",
                             k, (idx + k) % MW, s_axi_rdata, s_axi_rlast, mdl[(idx + k) % MW], (k == len));
                end
                if (mode == 0) s_axi_rready = 1;
                else if (mode == 1) begin s_axi_rready = tog; tog = ~tog; end
                else s_axi_rready = 1'($urandom_range(0, 1));
                if (s_axi_rready) k++;
            end else begin
                s_axi_rready = 1'($urandom_range(0, 1));
                if (seen) begin
                    n_vec++; n_err++;
                    $display("FAIL rvalid_gap beat %0d: rvalid=%b required 1", k, s_axi_rvalid);
                end
            end
        end
        if (k <= len) begin n_vec++; n_err++; $display("FAIL read_timeout: %0d beats of %0d required", k, len + 1); end
        @(negedge clk); s_axi_rready = 0;
        n_vec++;
        if (s_axi_rvalid !== 1'b0) begin n_err++; $display("FAIL read_end: rvalid=%b required 0", s_axi_rvalid); end
    endtask

    // dmode 0: random data/strobe, 1: fixed fd/fs, 2: random data full strobe
    task automatic write_beats(input int idx, input int len, input logic [2:0] size, input int nbeats,
                               input int bdelay, input int dmode, input logic [63:0] fd, input logic [7:0] fs);
        logic [63:0] d;
        logic [7:0]  s;
        logic [1:0]  exp;
        exp = (size != 3'd3 || nbeats != len + 1) ? 2'b10 : 2'b00;
        for (int b = 0; b < nbeats; b++) begin
            @(negedge clk);
            s_axi_arvalid = 0; s_axi_awvalid = 0;
            d = (dmode == 1) ? fd : {$urandom, $urandom};
            s = (dmode == 0) ? 8'($urandom) : ((dmode == 1) ? fs : 8'hFF);
            s_axi_wvalid = 1; s_axi_wdata = d; s_axi_wstrb = s; s_axi_wlast = (b == nbeats - 1);
            n_vec++;
            if (s_axi_wready !== 1'b1) begin n_err++; $display("FAIL wready beat %0d: wready=%b required 1", b, s_axi_wready); end
            if (b <= len)
                for (int j = 0; j < 8; j++) if (s[j]) mdl[(idx + b) % MW][j*8 +: 8] = d[j*8 +: 8];
        end
        @(negedge clk);
        s_axi_wvalid = 0; s_axi_wlast = 0;
        n_vec++;
        if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== exp) begin
            n_err++; $display("FAIL write_resp: bvalid=%b bresp=%b required 1 %b", s_axi_bvalid, s_axi_bresp, exp);
        end
        for (int i = 0; i < bdelay; i++) begin
            @(negedge clk);
            n_vec++;
            if (s_axi_bvalid !== 1'b1) begin n_err++; $display("FAIL bvalid_hold: bvalid=%b required 1", s_axi_bvalid); end
        end
        s_axi_bready = 1;
        @(negedge clk); s_axi_bready = 0;
        n_vec++;
        if (s_axi_bvalid !== 1'b0) begin n_err++; $display("FAIL write_end: bvalid=%b required 0", s_axi_bvalid); end
    endtask

    task automatic do_write(input int idx, input int len, input logic [2:0] size, input int nbeats,
                            input int bdelay, input int dmode, input logic [63:0] fd, input logic [7:0] fs);
        int w;
        drive_aw(idx, len, size, w);
        write_beats(idx, len, size, nbeats, bdelay, dmode, fd, fs);
    endtask

    task automatic do_read(input int idx, input int len, input logic [2:0] size, input int mode);
        int w;
        drive_ar(idx, len, size, w);
        read_beats(idx, len, mode);
    endtask

    task automatic test_reset();
        s_axi_arvalid = 1; s_axi_awvalid = 1;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if ({s_axi_arready, s_axi_awready, s_axi_rvalid, s_axi_rlast, s_axi_wready, s_axi_bvalid} !== 6'b0 ||
            s_axi_rdata !== 64'd0 || s_axi_bresp !== 2'b00) begin
            n_err++;
            $display("FAIL reset_values: ar/aw/rv/rl/wr/bv=%b rdata=%h bresp=%b required all zero",
                     {s_axi_arready, s_axi_awready, s_axi_rvalid, s_axi_rlast, s_axi_wready, s_axi_bvalid},
                     s_axi_rdata, s_axi_bresp);
        end
        s_axi_arvalid = 0; s_axi_awvalid = 0;
        @(negedge clk); reset = 0;
    endtask

    task automatic test_init();
        for (int base = 0; base < 64; base += 8) do_write(base, 7, 3'd3, 8, 0, 2, '0, '0);
        do_write(1016, 7, 3'd3, 8, 1, 2, '0, '0);
    endtask

    task automatic test_single_read();
        do_write(4, 0, 3'd3, 1, 1, 1, 64'hDEAD_BEEF_0123_4567, 8'hFF);
        do_read(4, 0, 3'd3, 0);
    endtask

    task automatic test_burst_backpressure();
        do_read(0, 7, 3'd3, 1);
    endtask

    task automatic test_strobe();
        do_write(30, 0, 3'd3, 1, 0, 1, 64'h0, 8'hFF);
        do_write(30, 0, 3'd3, 1, 2, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        do_read(30, 0, 3'd3, 0);
    endtask

    task automatic test_arbitration();
        reset = 1;
        @(negedge clk); reset = 0;
        s_axi_arvalid = 1; s_axi_araddr = 64'(11 * 8); s_axi_arlen = 0; s_axi_arsize = 3'd3;
        s_axi_awvalid = 1; s_axi_awaddr = 64'(10 * 8); s_axi_awlen = 0; s_axi_awsize = 3'd3;
        #1;
        n_vec++;
        if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b0) begin
            n_err++; $display("FAIL arb_first: awready=%b arready=%b required 1 0", s_axi_awready, s_axi_arready);
        end
        @(posedge clk);
        write_beats(10, 0, 3'd3, 1, 0, 2, '0, '0);
        s_axi_arvalid = 1; s_axi_awvalid = 1;
        #1;
        n_vec++;
        if (s_axi_arready !== 1'b1 || s_axi_awready !== 1'b0) begin
            n_err++; $display("FAIL arb_second: arready=%b awready=%b required 1 0", s_axi_arready, s_axi_awready);
        end
        @(posedge clk);
        read_beats(11, 0, 0);
    endtask

    task automatic test_mismatch();
        do_write(40, 3, 3'd3, 2, 0, 0, '0, '0);
        do_read(40, 3, 3'd3, 2);
        do_write(48, 1, 3'd3, 4, 1, 0, '0, '0);
        do_read(48, 3, 3'd3, 2);
        do_write(52, 1, 3'd2, 2, 0, 0, '0, '0);
        do_read(52, 1, 3'd3, 0);
        do_read(0, 3, 3'd1, 0);
    endtask

    task automatic test_back_to_back();
        int w;
        do_write(60, 2, 3'd3, 3, 0, 2, '0, '0);
        drive_ar(60, 2, 3'd3, w);
        n_vec++;
        if (w != 0) begin n_err++; $display("FAIL b2b_ar: handshake after %0d extra cycles required 0", w); end
        read_beats(60, 2, 0);
        drive_aw(61, 0, 3'd3, w);
        n_vec++;
        if (w != 0) begin n_err++; $display("FAIL b2b_aw: handshake after %0d extra cycles required 0", w); end
        write_beats(61, 0, 3'd3, 1, 0, 0, '0, '0);
    endtask

    task automatic test_random();
        int idx, len, nb;
        for (int it = 0; it < 30; it++) begin
            idx = $urandom_range(0, 54);
            len = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) begin
                nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : len + 1;
                do_write(idx, len, 3'd3, nb, $urandom_range(0, 3), 0, '0, '0);
            end else begin
                do_read(idx, len, 3'd3, 2);
            end
        end
    endtask

    task automatic test_wrap_reset();
        int w, t;
        do_read(MW - 1, 1, 3'd3, 0);
        drive_ar(MW - 1, 1, 3'd3, w);
        t = 0;
        do begin @(negedge clk); s_axi_arvalid = 0; t++; end while (s_axi_rvalid !== 1'b1 && t < 30);
        n_vec++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== mdl[MW - 1]) begin
            n_err++; $display("FAIL wrap_beat0: rvalid=%b rdata=%h required 1 %h", s_axi_rvalid, s_axi_rdata, mdl[MW - 1]);
        end
        s_axi_rready = 1;
        @(negedge clk);
        n_vec++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== mdl[0] || s_axi_rlast !== 1'b1) begin
            n_err++; $display("FAIL wrap_beat1: rvalid=%b rdata=%h rlast=%b required 1 %h 1",
                              s_axi_rvalid, s_axi_rdata, s_axi_rlast, mdl[0]);
        end
        reset = 1;
        #1;
        n_vec++;
        if (s_axi_rvalid !== 1'b0 || s_axi_rlast !== 1'b0 || s_axi_rdata !== 64'd0) begin
            n_err++; $display("FAIL reset_mid_read: rvalid=%b rlast=%b rdata=%h required 0 0 0",
                              s_axi_rvalid, s_axi_rlast, s_axi_rdata);
        end
        @(negedge clk); reset = 0; s_axi_rready = 0;
        do_read(5, 2, 3'd3, 0);
    endtask

    task automatic test_reset_write();
        int w;
        logic [63:0] d;
        drive_aw(20, 3, 3'd3, w);
        @(negedge clk);
        s_axi_awvalid = 0;
        d = {$urandom, $urandom};
        s_axi_wvalid = 1; s_axi_wdata = d; s_axi_wstrb = 8'hFF; s_axi_wlast = 0;
        mdl[20] = d;
        @(negedge clk);
        s_axi_wdata = {$urandom, $urandom};
        reset = 1;
        #1;
        n_vec++;
        if (s_axi_wready !== 1'b0 || s_axi_bvalid !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_write: wready=%b bvalid=%b required 0 0", s_axi_wready, s_axi_bvalid);
        end
        repeat (2) @(negedge clk);
        reset = 0; s_axi_wvalid = 0;
        do_read(20, 2, 3'd3, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_init();
        test_single_read();
        test_burst_backpressure();
        test_strobe();
        test_arbitration();
        test_mismatch();
        test_back_to_back();
        test_random();
        test_wrap_reset();
        test_reset_write();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
